// File: rtl/pwm_bank_if.sv
// Control, sample and status signals of the multi-channel PWM output stage.
interface pwm_bank_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 15
);
    logic                         enable;
    logic [CHANNELS*DATA_W-1:0]   sample_in;
    logic                         clip_clr;
    logic                         sample_tick;
    logic [ADDR_W-1:0]            addr;
    logic [CHANNELS-1:0]          pwm_out;
    logic [CHANNELS-1:0]          clip;

    modport master (
        output enable, sample_in, clip_clr,
        input  sample_tick, addr, pwm_out, clip
    );

    modport slave (
        input  enable, sample_in, clip_clr,
        output sample_tick, addr, pwm_out, clip
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM stage: sign-magnitude samples -> saturated duty values,
// per-period sample strobe and sample-ROM address counter.
module pwm_bank #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SHIFT    = 13,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned OFFSET   = 1
) (
    input logic       clk,
    input logic       rst,
    pwm_bank_if.slave bus
);

    localparam logic [WIDTH-1:0]  Half    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  Top     = {WIDTH{1'b1}};
    localparam logic [DATA_W-2:0] LimBi   = {{(DATA_W-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [DATA_W-2:0] LimUni  = {{(DATA_W-1-WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0]  DutyRst = (OFFSET != 0) ? Half : {WIDTH{1'b0}};

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    duty_q [CHANNELS];
    logic [WIDTH-1:0]    duty_d [CHANNELS];
    logic [CHANNELS-1:0] sat;
    logic [CHANNELS-1:0] clip_q, clip_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick;

    // Returns {saturated, duty}; the full shifted magnitude takes part in the range check.
    function automatic logic [WIDTH:0] conv(input logic [DATA_W-1:0] word);
        logic             sign;
        logic [DATA_W-2:0] f;
        logic [WIDTH-1:0] mag;
        logic             over;
        sign = word[DATA_W-1];
        f    = word[DATA_W-2:0] >> SHIFT;
        if (OFFSET != 0) begin
            over = (f > LimBi);
            mag  = over ? (Half - 1'b1) : f[WIDTH-1:0];
            return {over, sign ? (Half - mag) : (Half + mag)};
        end else begin
            if (sign) begin
                return {(f != '0), {WIDTH{1'b0}}};
            end
            over = (f > LimUni);
            return {over, over ? Top : f[WIDTH-1:0]};
        end
    endfunction

    always_comb begin
        tick = bus.enable & (cnt_q == Top);
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        clip_d = clip_q;
        sat    = '0;
        pwm_d  = '0;
        if (bus.enable) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (tick) begin
            addr_d = addr_q + 1'b1;
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            {sat[i], duty_d[i]} = conv(bus.sample_in[i*DATA_W +: DATA_W]);
            if (!tick) begin
                sat[i]    = 1'b0;
                duty_d[i] = duty_q[i];
            end
            pwm_d[i] = bus.enable & (cnt_q < duty_q[i]);
        end
        // Clear first so a saturation landing in the same cycle survives.
        if (bus.clip_clr) begin
            clip_d = '0;
        end
        clip_d = clip_d | sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            clip_q <= '0;
            pwm_q  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= DutyRst;
            end
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            clip_q <= clip_d;
            pwm_q  <= pwm_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign bus.sample_tick = tick;
    assign bus.addr        = addr_q;
    assign bus.pwm_out     = pwm_q;
    assign bus.clip        = clip_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: a bipolar and a unipolar instance against an arithmetic reference model.
module tb_pwm_bank;

    localparam int W  = 6;
    localparam int P  = 64;
    localparam int AW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic [31:0] smp [2][2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_bank_if #(.CHANNELS(2), .DATA_W(DW), .ADDR_W(AW)) bus_b ();
    pwm_bank_if #(.CHANNELS(2), .DATA_W(DW), .ADDR_W(AW)) bus_u ();

    assign bus_b.enable    = en;
    assign bus_b.clip_clr  = clr;
    assign bus_b.sample_in = {smp[0][1], smp[0][0]};
    assign bus_u.enable    = en;
    assign bus_u.clip_clr  = clr;
    assign bus_u.sample_in = {smp[1][1], smp[1][0]};

    pwm_bank #(.CHANNELS(2), .WIDTH(W), .DATA_W(DW), .SHIFT(13), .ADDR_W(AW), .OFFSET(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    pwm_bank #(.CHANNELS(2), .WIDTH(W), .DATA_W(DW), .SHIFT(13), .ADDR_W(AW), .OFFSET(0))
        dut_u (.clk(clk), .rst(rst), .bus(bus_u));

    // Reference state: index 0 = bipolar instance, 1 = unipolar instance.
    int m_cnt;
    int m_addr;
    int m_duty [2][2];
    bit m_clip [2][2];
    bit m_pwm  [2][2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed value clamped to the representable duty range.
    task automatic ref_conv(input int off, input logic [31:0] w, output int duty, output bit sat);
        longint v;
        v = longint'(w[30:0] >> 13);
        if (w[31]) v = -v;
        if (off != 0) begin
            sat  = (v > 31) || (v < -31);
            duty = 32 + int'((v > 31) ? 31 : ((v < -31) ? -31 : v));
        end else begin
            sat  = (v < 0) || (v > 63);
            duty = int'((v < 0) ? 0 : ((v > 63) ? 63 : v));
        end
    endtask

    task automatic reset_model();
        m_cnt  = 0;
        m_addr = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                m_duty[d][i] = (d == 0) ? 32 : 0;
                m_clip[d][i] = 1'b0;
                m_pwm[d][i]  = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        bit tk;
        tk = rst && en && (m_cnt == P - 1);
        chk("b_pwm",  bus_b.pwm_out, {m_pwm[0][1], m_pwm[0][0]});
        chk("b_clip", bus_b.clip,    {m_clip[0][1], m_clip[0][0]});
        chk("b_addr", bus_b.addr,    m_addr);
        chk("b_tick", bus_b.sample_tick, tk);
        chk("u_pwm",  bus_u.pwm_out, {m_pwm[1][1], m_pwm[1][0]});
        chk("u_clip", bus_u.clip,    {m_clip[1][1], m_clip[1][0]});
        chk("u_addr", bus_u.addr,    m_addr);
        chk("u_tick", bus_u.sample_tick, tk);
    endtask

    // One clock: predict from pre-edge inputs, advance, then compare.
    task automatic cycle();
        int n_cnt, n_addr, nd;
        int n_duty [2][2];
        bit n_clip [2][2];
        bit n_pwm  [2][2];
        bit tk, s;
        tk     = en && (m_cnt == P - 1);
        n_cnt  = en ? (m_cnt + 1) % P : m_cnt;
        n_addr = tk ? (m_addr + 1) % (1 << AW) : m_addr;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                n_pwm[d][i]  = en && (m_cnt < m_duty[d][i]);
                n_duty[d][i] = m_duty[d][i];
                n_clip[d][i] = clr ? 1'b0 : m_clip[d][i];
                if (tk) begin
                    ref_conv((d == 0) ? 1 : 0, smp[d][i], nd, s);
                    n_duty[d][i] = nd;
                    if (s) n_clip[d][i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            reset_model();
        end else begin
            m_cnt  = n_cnt;
            m_addr = n_addr;
            m_duty = n_duty;
            m_clip = n_clip;
            m_pwm  = n_pwm;
        end
        compare_all();
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!bus_b.sample_tick && n < 300) begin
            cycle();
            n++;
        end
        if (!bus_b.sample_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic count_period(output int hb0, output int hb1, output int hu0, output int hu1);
        hb0 = 0; hb1 = 0; hu0 = 0; hu1 = 0;
        for (int k = 0; k < P; k++) begin
            cycle();
            hb0 += int'(bus_b.pwm_out[0]);
            hb1 += int'(bus_b.pwm_out[1]);
            hu0 += int'(bus_u.pwm_out[0]);
            hu1 += int'(bus_u.pwm_out[1]);
        end
    endtask

    function automatic logic [31:0] rand_sample();
        logic        sg;
        logic [30:0] mag;
        int          f;
        int          edges [4];
        edges = '{31, 32, 63, 64};
        sg    = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: begin
                f   = $urandom_range(0, 70);
                mag = 31'(f << 13);
            end
            1: mag = 31'($urandom);
            2: begin
                f   = edges[$urandom_range(0, 3)];
                mag = 31'((f << 13) + $urandom_range(0, 8191));
            end
            3: begin
                sg  = 1'b1;
                mag = 31'($urandom_range(0, 8191));
            end
            default: begin
                f   = $urandom_range(0, 63);
                mag = 31'(f << 13);
            end
        endcase
        return {sg, mag};
    endfunction

    initial begin
        int n, t, a0, hb0, hb1, hu0, hu1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) smp[d][i] = 32'h0;
        end
        reset_model();
        #3;
        compare_all();
        repeat (2) cycle();

        // Reset release and first period
        smp[0][0] = 32'h0000A000;
        smp[0][1] = 32'h8000A000;
        smp[1][0] = 32'h0007E000;
        smp[1][1] = 32'h80002000;
        rst = 1'b1;
        en  = 1'b1;
        n = 1;
        while (!bus_b.sample_tick && n < 200) begin
            cycle();
            n++;
        end
        chk("first_tick_cycle", n, 64);
        cycle();
        chk("addr_after_tick", bus_b.addr, 1);
        count_period(hb0, hb1, hu0, hu1);
        chk("b_high_pos5", hb0, 37);
        chk("b_high_neg5", hb1, 27);
        chk("u_high_63",   hu0, 63);
        chk("u_high_neg",  hu1, 0);
        chk("b_clip_inrange", bus_b.clip, 2'b00);
        chk("u_clip_mixed",   bus_u.clip, 2'b10);

        // Saturation
        smp[0][0] = 32'h80050000;
        smp[1][0] = 32'h00080000;
        wait_tick();
        cycle();
        chk("b_sat_clip", bus_b.clip, 2'b01);
        chk("u_sat_clip", bus_u.clip, 2'b11);
        count_period(hb0, hb1, hu0, hu1);
        chk("b_high_sat", hb0, 1);
        chk("u_high_sat", hu0, 63);

        // Clear coinciding with a saturating tick
        wait_tick();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("b_clip_set_wins", bus_b.clip, 2'b01);
        chk("u_clip_set_wins", bus_u.clip, 2'b11);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("b_clip_clr", bus_b.clip, 2'b00);

        // Hold mid-period
        repeat (10) cycle();
        a0 = m_addr;
        en = 1'b0;
        t  = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            t += int'(bus_b.sample_tick);
            chk("hold_pwm", {bus_b.pwm_out, bus_u.pwm_out}, 4'b0000);
        end
        chk("hold_no_tick", t, 0);
        chk("hold_addr", bus_b.addr, a0);
        en = 1'b1;

        // Address wrap over eight periods
        a0 = m_addr;
        t  = 0;
        for (int k = 0; k < 8 * P; k++) begin
            cycle();
            t += int'(bus_b.sample_tick);
        end
        chk("wrap_ticks", t, 8);
        chk("wrap_addr", bus_b.addr, a0);

        // Randomized run
        for (int k = 0; k < 1500; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 2; i++) begin
                    if ($urandom_range(0, 7) == 0) smp[d][i] = rand_sample();
                end
            end
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 31) == 0);
            cycle();
        end

        // Asynchronous reset with duty 37 active
        en  = 1'b1;
        clr = 1'b0;
        smp[0][0] = 32'h0000A000;
        smp[0][1] = 32'h8000A000;
        smp[1][0] = 32'h0007E000;
        smp[1][1] = 32'h80002000;
        wait_tick();
        cycle();
        repeat (10) cycle();
        #2;
        rst = 1'b0;
        #1;
        reset_model();
        compare_all();
        chk("async_addr", bus_b.addr, 0);
        chk("async_clip", {bus_b.clip, bus_u.clip}, 4'b0000);
        repeat (3) cycle();
        rst = 1'b1;
        count_period(hb0, hb1, hu0, hu1);
        chk("b_mid_ch0", hb0, 32);
        chk("b_mid_ch1", hb1, 32);
        chk("u_zero_ch0", hu0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
